// File: rtl/gmii_mac_tx_if.sv
// Payload-in / GMII-out signal bundle for the transmit MAC.
// master = packet source side, slave = MAC side.
interface gmii_mac_tx_if;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic [15:0] s_ethertype;
  logic [7:0]  txd;
  logic        txen;
  logic        txer;
  logic        busy;
  logic        frame_done;
  logic        frame_err;

  modport master (
    output s_data, s_valid, s_last, s_ethertype,
    input  s_ready, txd, txen, txer, busy, frame_done, frame_err
  );

  modport slave (
    input  s_data, s_valid, s_last, s_ethertype,
    output s_ready, txd, txen, txer, busy, frame_done, frame_err
  );
endinterface

// File: rtl/gmii_mac_tx.sv
// GMII transmit MAC: preamble/SFD, header, payload with zero pad,
// CRC-32 FCS and a fixed inter-packet gap. The FSM state names the
// byte that will be launched on the next edge; all GMII pins are flops.
module gmii_mac_tx #(
  parameter logic [47:0] MAC_DST     = 48'h38_6b_1c_1d_f5_65,
  parameter logic [47:0] MAC_SRC     = 48'h02_00_00_00_00_01,
  parameter int          MIN_PAYLOAD = 46,
  parameter int          MAX_PAYLOAD = 1500,
  parameter int          IPG_BYTES   = 12
) (
  input logic          sys_clk,
  input logic          reset,
  gmii_mac_tx_if.slave bus
);
  localparam logic [10:0] MIN_P    = 11'(MIN_PAYLOAD);
  localparam logic [10:0] MAX_P    = 11'(MAX_PAYLOAD);
  localparam logic [7:0]  IPG_LAST = 8'(IPG_BYTES - 1);
  localparam logic [31:0] POLY     = 32'hEDB88320;

  typedef enum logic [3:0] {
    IDLE, PREAMBLE, SFD, HEADER, PAYLOAD, PAD, FCS, DROP, IPG
  } state_t;

  state_t      r_state, w_state;
  logic [7:0]  r_cnt, w_cnt;
  logic [10:0] r_pcnt, w_pcnt, w_pcnt_inc;
  logic [15:0] r_eth, w_eth;
  logic [31:0] r_crc, w_crc;
  logic [7:0]  r_txd, w_txd;
  logic        r_txen, w_txen, r_txer, w_txer;
  logic        r_ferr, w_ferr, r_fcs_last, w_fcs_last, r_fdone;
  logic        w_crc_en, w_crc_init, w_s_ready;
  logic [111:0] w_hdr, w_hdr_sh;
  logic [31:0] w_crc_n, w_fcs_sh;

  // Reflected CRC-32, one byte per call, LSB of the byte first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] x;
    x = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++)
      x = x[0] ? ((x >> 1) ^ POLY) : (x >> 1);
    return x;
  endfunction

  // Header byte r_cnt (0..13) and FCS byte r_cnt (0..3, LSB byte first).
  always_comb begin
    w_hdr    = {MAC_DST, MAC_SRC, r_eth};
    w_hdr_sh = w_hdr << {r_cnt, 3'b000};
    w_crc_n  = ~r_crc;
    w_fcs_sh = w_crc_n >> {r_cnt[1:0], 3'b000};
  end

  // Next state, next GMII byte and CRC control.
  always_comb begin
    w_state    = r_state;
    w_cnt      = r_cnt;
    w_pcnt     = r_pcnt;
    w_eth      = r_eth;
    w_txd      = 8'h00;
    w_txen     = 1'b0;
    w_txer     = 1'b0;
    w_ferr     = 1'b0;
    w_crc_en   = 1'b0;
    w_crc_init = 1'b0;
    w_s_ready  = 1'b0;
    w_pcnt_inc = r_pcnt + 11'd1;
    w_fcs_last = (r_state == FCS) && (r_cnt == 8'd3);
    case (r_state)
      IDLE: if (bus.s_valid) begin
        w_eth      = bus.s_ethertype;
        w_txd      = 8'h55;
        w_txen     = 1'b1;
        w_cnt      = 8'd1;
        w_crc_init = 1'b1;
        w_state    = PREAMBLE;
      end
      PREAMBLE: begin
        w_txd  = 8'h55;
        w_txen = 1'b1;
        w_cnt  = r_cnt + 8'd1;
        if (r_cnt == 8'd6) w_state = SFD;
      end
      SFD: begin
        w_txd   = 8'hD5;
        w_txen  = 1'b1;
        w_cnt   = 8'd0;
        w_state = HEADER;
      end
      HEADER: begin
        w_txd    = w_hdr_sh[111:104];
        w_txen   = 1'b1;
        w_crc_en = 1'b1;
        w_cnt    = r_cnt + 8'd1;
        if (r_cnt == 8'd13) begin
          w_pcnt  = 11'd0;
          w_state = PAYLOAD;
        end
      end
      PAYLOAD: begin
        w_s_ready = 1'b1;
        if (r_pcnt == MAX_P || !bus.s_valid) begin
          // Oversize or underrun: one poisoned byte, then discard the rest.
          w_txen  = 1'b1;
          w_txer  = 1'b1;
          w_ferr  = 1'b1;
          w_cnt   = 8'd0;
          w_state = (bus.s_valid && bus.s_last) ? IPG : DROP;
        end else begin
          w_txd    = bus.s_data;
          w_txen   = 1'b1;
          w_crc_en = 1'b1;
          w_pcnt   = w_pcnt_inc;
          if (bus.s_last) begin
            w_cnt   = 8'd0;
            w_state = (w_pcnt_inc < MIN_P) ? PAD : FCS;
          end
        end
      end
      PAD: begin
        w_txen   = 1'b1;
        w_crc_en = 1'b1;
        w_pcnt   = w_pcnt_inc;
        if (w_pcnt_inc == MIN_P) begin
          w_cnt   = 8'd0;
          w_state = FCS;
        end
      end
      FCS: begin
        w_txd  = w_fcs_sh[7:0];
        w_txen = 1'b1;
        w_cnt  = r_cnt + 8'd1;
        if (r_cnt == 8'd3) begin
          w_cnt   = 8'd0;
          w_state = IPG;
        end
      end
      DROP: begin
        w_s_ready = 1'b1;
        if (bus.s_valid && bus.s_last) begin
          w_cnt   = 8'd0;
          w_state = IPG;
        end
      end
      IPG: begin
        if (r_cnt == IPG_LAST) w_state = IDLE;
        else                   w_cnt   = r_cnt + 8'd1;
      end
      default: w_state = IDLE;
    endcase
    w_crc = w_crc_init ? 32'hFFFFFFFF :
            w_crc_en   ? crc32_byte(r_crc, w_txd) : r_crc;
  end

  // State, counters, CRC and registered GMII outputs.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= 8'd0;
      r_pcnt     <= 11'd0;
      r_eth      <= 16'h0;
      r_crc      <= 32'hFFFFFFFF;
      r_txd      <= 8'h00;
      r_txen     <= 1'b0;
      r_txer     <= 1'b0;
      r_ferr     <= 1'b0;
      r_fcs_last <= 1'b0;
      r_fdone    <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_cnt      <= w_cnt;
      r_pcnt     <= w_pcnt;
      r_eth      <= w_eth;
      r_crc      <= w_crc;
      r_txd      <= w_txd;
      r_txen     <= w_txen;
      r_txer     <= w_txer;
      r_ferr     <= w_ferr;
      r_fcs_last <= w_fcs_last;
      // frame_done lands on the first idle cycle after the last FCS byte
      r_fdone    <= r_fcs_last;
    end
  end

  assign bus.s_ready    = w_s_ready;
  assign bus.txd        = r_txd;
  assign bus.txen       = r_txen;
  assign bus.txer       = r_txer;
  assign bus.busy       = (r_state != IDLE);
  assign bus.frame_done = r_fdone;
  assign bus.frame_err  = r_ferr;
endmodule

// File: tb/tb_gmii_mac_tx.sv
// Self-checking bench for gmii_mac_tx: builds each expected frame from
// the Ethernet framing rules and compares it with a per-cycle pin log.
module tb_gmii_mac_tx;
  localparam logic [47:0] DST = 48'h38_6b_1c_1d_f5_65;
  localparam logic [47:0] SRC = 48'h02_00_00_00_00_01;
  localparam int MINP = 46;
  localparam int IPG  = 12;

  typedef logic [7:0] u8;
  typedef struct packed {
    logic [7:0] d;
    logic en, er, fd, fe, rdy, bsy;
  } rec_t;

  logic sys_clk = 1'b0;
  logic reset;
  gmii_mac_tx_if bus();
  gmii_mac_tx dut (.sys_clk(sys_clk), .reset(reset), .bus(bus));

  always #4 sys_clk = ~sys_clk;

  int   n_chk = 0;
  int   n_err = 0;
  rec_t log_q[$];
  bit   log_on = 0;
  u8    pay[$];
  u8    exp_q[$];

  always @(negedge sys_clk) begin
    rec_t r;
    if (log_on) begin
      r.d = bus.txd; r.en = bus.txen; r.er = bus.txer; r.fd = bus.frame_done;
      r.fe = bus.frame_err; r.rdy = bus.s_ready; r.bsy = bus.busy;
      log_q.push_back(r);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // IEEE 802.3 CRC-32, reflected, one bit at a time.
  function automatic logic [31:0] ref_crc(input logic [31:0] c, input u8 d);
    logic [31:0] r;
    logic fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[0] ^ d[i];
      r  = {1'b0, r[31:1]};
      if (fb) r = r ^ 32'hEDB88320;
    end
    return r;
  endfunction

  task automatic push_prefix(input logic [15:0] eth);
    logic [47:0] a;
    exp_q.delete();
    repeat (7) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    a = DST; for (int i = 0; i < 6; i++) exp_q.push_back(a[47-8*i -: 8]);
    a = SRC; for (int i = 0; i < 6; i++) exp_q.push_back(a[47-8*i -: 8]);
    exp_q.push_back(eth[15:8]);
    exp_q.push_back(eth[7:0]);
  endtask

  task automatic build_good(input logic [15:0] eth);
    logic [31:0] c;
    push_prefix(eth);
    foreach (pay[i]) exp_q.push_back(pay[i]);
    for (int i = pay.size(); i < MINP; i++) exp_q.push_back(8'h00);
    c = 32'hFFFFFFFF;
    for (int i = 8; i < exp_q.size(); i++) c = ref_crc(c, exp_q[i]);
    c = ~c;
    for (int i = 0; i < 4; i++) exp_q.push_back(u8'(c >> (8*i)));
  endtask

  task automatic build_err(input logic [15:0] eth, input int k);
    push_prefix(eth);
    for (int i = 0; i < k; i++) exp_q.push_back(pay[i]);
    exp_q.push_back(8'h00);
  endtask

  task automatic rand_pay(input int n);
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back(u8'($urandom));
  endtask

  task automatic drive_stream(input int n, input int gap, input logic [15:0] eth);
    bit rdy;
    int w;
    bus.s_ethertype = eth;
    for (int i = 0; i < n; i++) begin
      if (i == gap) begin
        bus.s_valid = 1'b0;
        @(posedge sys_clk); #1;
      end
      bus.s_valid = 1'b1; bus.s_data = pay[i]; bus.s_last = (i == n-1);
      w = 0; rdy = 0;
      do begin
        @(negedge sys_clk); rdy = bus.s_ready;
        @(posedge sys_clk); #1; w++;
      end while (!rdy && w < 400);
      if (!rdy) begin
        chk("drive_ready_timeout", rdy, 1);
        bus.s_valid = 1'b0; bus.s_last = 1'b0;
        return;
      end
    end
    bus.s_valid = 1'b0; bus.s_last = 1'b0;
  endtask

  task automatic wait_idle();
    bit seen;
    seen = 0;
    for (int i = 0; i < 4000 && !seen; i++) begin
      @(negedge sys_clk);
      if (!bus.busy) seen = 1;
    end
    chk("idle_reached", seen, 1);
    repeat (2) @(posedge sys_clk);
    #1;
  endtask

  task automatic find_run(input int nth, output int s, output int e);
    int cnt;
    cnt = 0; s = -1; e = -1;
    for (int i = 0; i < log_q.size(); i++) begin
      if (log_q[i].en && (i == 0 || !log_q[i-1].en)) begin
        if (cnt == nth) begin
          s = i; e = i;
          while (e < log_q.size() && log_q[e].en) e++;
          return;
        end
        cnt++;
      end
    end
  endtask

  task automatic check_frame(input string tag, input int nth, input bit is_err, input int exp_rdy);
    int s, e, nxt, lim, mism, ner, nfe, nfd, nrdy;
    logic [31:0] c;
    find_run(nth, s, e);
    chk({tag, " found"}, (s >= 0), 1);
    if (s < 0) return;
    chk({tag, " len"}, e - s, exp_q.size());
    mism = 0;
    for (int i = 0; i < e - s && i < exp_q.size(); i++)
      if (log_q[s+i].d !== exp_q[i]) mism++;
    chk({tag, " data_mismatches"}, mism, 0);
    nxt = -1;
    for (int i = e; i < log_q.size(); i++) if (log_q[i].en) begin nxt = i; break; end
    lim = (nxt < 0) ? log_q.size() : nxt;
    ner = 0; nfe = 0; nfd = 0; nrdy = 0;
    for (int i = s; i < lim; i++) begin
      ner += log_q[i].er; nfe += log_q[i].fe; nfd += log_q[i].fd; nrdy += log_q[i].rdy;
    end
    chk({tag, " txer_count"}, ner, is_err);
    chk({tag, " frame_err_count"}, nfe, is_err);
    chk({tag, " frame_done_count"}, nfd, !is_err);
    chk({tag, " ready_cycles"}, nrdy, exp_rdy);
    if (is_err) chk({tag, " txer_on_last"}, log_q[e-1].er, 1);
    else begin
      chk({tag, " frame_done_pos"}, (e < log_q.size()) ? log_q[e].fd : 1'b0, 1);
      c = 32'hFFFFFFFF;
      for (int i = s + 8; i < e; i++) c = ref_crc(c, log_q[i].d);
      chk({tag, " crc_residue"}, c, 32'hDEBB20E3);
    end
    if (nxt >= 0) chk({tag, " ipg_gap"}, nxt - e, IPG);
  endtask

  task automatic start_log();
    log_q.delete();
    log_on = 1;
  endtask

  initial begin
    u8 p1[$];
    logic [15:0] eth, eth2;
    int lens[6];

    bus.s_valid = 0; bus.s_last = 0; bus.s_data = 0; bus.s_ethertype = 0;
    reset = 1'b1;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("rst txd", bus.txd, 0);
    chk("rst txen", bus.txen, 0);
    chk("rst txer", bus.txer, 0);
    chk("rst s_ready", bus.s_ready, 0);
    chk("rst busy", bus.busy, 0);
    chk("rst frame_done", bus.frame_done, 0);
    chk("rst frame_err", bus.frame_err, 0);
    @(posedge sys_clk); #1 reset = 1'b0;
    repeat (2) @(posedge sys_clk); #1;

    // minimum payload 0x00..0x2D
    pay.delete();
    for (int i = 0; i < 46; i++) pay.push_back(u8'(i));
    start_log(); drive_stream(46, -1, 16'h88B5); wait_idle();
    build_good(16'h88B5); check_frame("min46", 0, 0, 46);

    // 1-byte payload, padded
    pay.delete(); pay.push_back(8'hAB);
    start_log(); drive_stream(1, -1, 16'h0800); wait_idle();
    build_good(16'h0800); check_frame("one_byte", 0, 0, 1);

    // random payloads around the pad boundary and beyond
    lens = '{45, 46, 47, 60, 0, 0};
    lens[4] = $urandom_range(1, 200);
    lens[5] = $urandom_range(1, 200);
    foreach (lens[k]) begin
      eth = 16'($urandom);
      rand_pay(lens[k]);
      start_log(); drive_stream(lens[k], -1, eth); wait_idle();
      build_good(eth); check_frame($sformatf("rand_len%0d", lens[k]), 0, 0, lens[k]);
    end

    // maximum payload
    eth = 16'($urandom); rand_pay(1500);
    start_log(); drive_stream(1500, -1, eth); wait_idle();
    build_good(eth); check_frame("max1500", 0, 0, 1500);

    // oversize: 1501 bytes, last arrives on the error cycle
    eth = 16'($urandom); rand_pay(1501);
    start_log(); drive_stream(1501, -1, eth); wait_idle();
    build_err(eth, 1500); check_frame("oversize", 0, 1, 1501);

    // underrun at payload byte 10
    eth = 16'($urandom); rand_pay(30);
    start_log(); drive_stream(30, 10, eth); wait_idle();
    build_err(eth, 10); check_frame("underrun", 0, 1, 31);

    // back-to-back frames, second s_valid asserted during IPG
    eth = 16'($urandom); eth2 = 16'($urandom);
    rand_pay(50); p1 = pay;
    start_log(); drive_stream(50, -1, eth);
    rand_pay(20); drive_stream(20, -1, eth2); wait_idle();
    build_good(eth2); check_frame("b2b_second", 1, 0, 20);
    pay = p1; build_good(eth); check_frame("b2b_first", 0, 0, 50);

    // reset in the middle of the header
    log_on = 0;
    rand_pay(20);
    bus.s_ethertype = 16'h86DD; bus.s_data = pay[0]; bus.s_last = 0; bus.s_valid = 1;
    repeat (11) @(posedge sys_clk);
    #2;
    chk("pre_rst txen", bus.txen, 1);
    chk("pre_rst busy", bus.busy, 1);
    reset = 1'b1;
    #1;
    chk("async_rst txen", bus.txen, 0);
    chk("async_rst txer", bus.txer, 0);
    chk("async_rst s_ready", bus.s_ready, 0);
    chk("async_rst busy", bus.busy, 0);
    chk("async_rst txd", bus.txd, 0);
    bus.s_valid = 0;
    repeat (2) @(posedge sys_clk);
    #1 reset = 1'b0;
    @(posedge sys_clk); #1;
    eth = 16'($urandom);
    start_log(); drive_stream(20, -1, eth); wait_idle();
    build_good(eth); check_frame("after_reset", 0, 0, 20);

    log_on = 0;
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
